// File: rtl/tlb_entry_array.sv
// tlb_entry_array: JTLB entry storage for the CP0 TLBR/TLBWI/TLBP path plus one
// pipelined MMU translation lookup port. All results are registered (1-cycle latency).
//
// Entry layout (78 bits, MSB first):
//   {vpn2[18:0], asid[7:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1}
// Lookup result layout (42 bits, MSB first):
//   {phy_addr[31:0], which[3:0], miss, dirty, valid, cache_flag[2:0]}
//
// Handshake: there is no ready side. A lookup is accepted on every rising edge
// where lk_req=1; exactly one cycle later lk_rvalid=1 and lk_result carries its
// answer. lk_result holds its last value while lk_req=0. Reset cancels any
// request sampled on the same edge.
module tlb_entry_array #(
  parameter int TLB_ENTRIES = 16,
  localparam int IW = $clog2(TLB_ENTRIES)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [IW-1:0] tlbrw_index,
  input  logic          tlbrw_we,
  input  logic [77:0]   tlbrw_wdata,
  output logic [77:0]   tlbrw_rdata,
  input  logic [31:0]   tlbp_entry_hi,
  output logic [31:0]   tlbp_index,
  input  logic          lk_req,
  input  logic [31:0]   lk_vaddr,
  input  logic [7:0]    lk_asid,
  output logic          lk_rvalid,
  output logic [41:0]   lk_result
);

  // Reset value of lk_result: everything zero except the miss bit.
  localparam logic [41:0] LK_RESULT_MISS = 42'h20;
  localparam logic [31:0] PROBE_MISS     = 32'h8000_0000;

  logic [77:0]          entry_q [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] live_q;

  logic [TLB_ENTRIES-1:0] probe_match;
  logic [TLB_ENTRIES-1:0] lk_match;
  logic                 probe_hit;
  logic [IW-1:0]        probe_idx;
  logic                 lk_hit;
  logic [IW-1:0]        lk_idx;
  logic [77:0]          lk_entry;
  logic [19:0]          lk_pfn;
  logic [2:0]           lk_c;
  logic                 lk_d;
  logic                 lk_v;
  logic [41:0]          lk_next;
  logic [31:0]          probe_next;

  // Entry storage and live bits; a write marks its slot live.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < TLB_ENTRIES; i++) entry_q[i] <= '0;
      live_q <= '0;
    end else if (tlbrw_we) begin
      entry_q[tlbrw_index] <= tlbrw_wdata;
      live_q[tlbrw_index]  <= 1'b1;
    end
  end

  // Per-entry match against the probe key and the lookup key; dead entries never match.
  always_comb begin
    probe_match = '0;
    lk_match    = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      probe_match[i] = live_q[i] && (entry_q[i][77:59] == tlbp_entry_hi[31:13]) &&
                       (entry_q[i][50] || (entry_q[i][58:51] == tlbp_entry_hi[7:0]));
      lk_match[i]    = live_q[i] && (entry_q[i][77:59] == lk_vaddr[31:13]) &&
                       (entry_q[i][50] || (entry_q[i][58:51] == lk_asid));
    end
  end

  // Priority encoders: scanning downward leaves the lowest matching index.
  always_comb begin
    probe_hit = 1'b0;
    probe_idx = '0;
    lk_hit    = 1'b0;
    lk_idx    = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (probe_match[i]) begin
        probe_hit = 1'b1;
        probe_idx = IW'(i);
      end
      if (lk_match[i]) begin
        lk_hit = 1'b1;
        lk_idx = IW'(i);
      end
    end
  end

  // Translation: vaddr[12] picks the odd/even page half of the hit entry.
  always_comb begin
    lk_entry = entry_q[lk_idx];
    if (lk_vaddr[12]) begin
      lk_pfn = lk_entry[24:5];
      lk_c   = lk_entry[4:2];
      lk_d   = lk_entry[1];
      lk_v   = lk_entry[0];
    end else begin
      lk_pfn = lk_entry[49:30];
      lk_c   = lk_entry[29:27];
      lk_d   = lk_entry[26];
      lk_v   = lk_entry[25];
    end
    lk_next    = LK_RESULT_MISS;
    probe_next = PROBE_MISS;
    if (lk_hit) lk_next = {lk_pfn, lk_vaddr[11:0], 4'(lk_idx), 1'b0, lk_d, lk_v, lk_c};
    if (probe_hit) probe_next = 32'(probe_idx);
  end

  // Registered read, probe and lookup results; all see pre-write contents.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tlbrw_rdata <= '0;
      tlbp_index  <= PROBE_MISS;
      lk_rvalid   <= 1'b0;
      lk_result   <= LK_RESULT_MISS;
    end else begin
      tlbrw_rdata <= live_q[tlbrw_index] ? entry_q[tlbrw_index] : '0;
      tlbp_index  <= probe_next;
      lk_rvalid   <= lk_req;
      if (lk_req) lk_result <= lk_next;
    end
  end

endmodule

// File: tb/tb_tlb_entry_array.sv
// tb_tlb_entry_array: directed and randomized checks of tlb_entry_array against
// an array-based reference model of the TLB rules.
module tb_tlb_entry_array;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] phy;
    logic [3:0]  which;
    logic        miss;
    logic        dirty;
    logic        valid;
    logic [2:0]  cf;
  } tlb_result_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  tlbrw_index;
  logic        tlbrw_we;
  logic [77:0] tlbrw_wdata;
  logic [77:0] tlbrw_rdata;
  logic [31:0] tlbp_entry_hi;
  logic [31:0] tlbp_index;
  logic        lk_req;
  logic [31:0] lk_vaddr;
  logic [7:0]  lk_asid;
  logic        lk_rvalid;
  logic [41:0] lk_result;

  always #5 clk = ~clk;

  tlb_entry_array #(.TLB_ENTRIES(16)) dut (
    .clk(clk), .resetn(resetn),
    .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we),
    .tlbrw_wdata(tlbrw_wdata), .tlbrw_rdata(tlbrw_rdata),
    .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
    .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_asid(lk_asid),
    .lk_rvalid(lk_rvalid), .lk_result(lk_result)
  );

  // ---------------- reference model ----------------
  tlb_entry_t  m_ent [16];
  bit          m_live [16];
  tlb_result_t exp_res;
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic int m_find(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int i = 0; i < 16; i++)
      if (m_live[i] && m_ent[i].vpn2 == vpn2 && (m_ent[i].g || m_ent[i].asid == asid))
        return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_probe(input logic [31:0] hi);
    int h;
    h = m_find(hi[31:13], hi[7:0]);
    return (h < 0) ? 32'h8000_0000 : 32'(h);
  endfunction

  function automatic tlb_result_t m_lookup(input logic [31:0] va, input logic [7:0] asid);
    tlb_result_t r;
    tlb_entry_t  e;
    int h;
    r = '0;
    h = m_find(va[31:13], asid);
    if (h < 0) begin
      r.miss = 1'b1;
    end else begin
      e = m_ent[h];
      r.which = 4'(h);
      if (va[12]) begin
        r.phy = {e.pfn1, va[11:0]}; r.dirty = e.d1; r.valid = e.v1; r.cf = e.c1;
      end else begin
        r.phy = {e.pfn0, va[11:0]}; r.dirty = e.d0; r.valid = e.v0; r.cf = e.c0;
      end
    end
    return r;
  endfunction

  function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid,
                                    input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                                    input logic d0, input logic v0, input logic [19:0] pfn1,
                                    input logic [2:0] c1, input logic d1, input logic v1);
    tlb_entry_t e;
    e = '{vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: predict from the model (pre-write state), clock, then compare.
  task automatic step(input string tag);
    tlb_entry_t  e_rd;
    logic [31:0] e_pr;
    logic        e_rv;
    if (!resetn) begin
      e_rd = '0;
      e_pr = 32'h8000_0000;
      e_rv = 1'b0;
      exp_res = '0;
      exp_res.miss = 1'b1;
      for (int i = 0; i < 16; i++) begin
        m_live[i] = 1'b0;
        m_ent[i]  = '0;
      end
    end else begin
      e_rd = m_live[tlbrw_index] ? m_ent[tlbrw_index] : '0;
      e_pr = m_probe(tlbp_entry_hi);
      e_rv = lk_req;
      if (lk_req) exp_res = m_lookup(lk_vaddr, lk_asid);
      if (tlbrw_we) begin
        m_ent[tlbrw_index]  = tlbrw_wdata;
        m_live[tlbrw_index] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_rdata"}, tlbrw_rdata, e_rd);
    chk({tag, "_probe"}, 78'(tlbp_index), 78'(e_pr));
    chk({tag, "_rvalid"}, 78'(lk_rvalid), 78'(e_rv));
    chk({tag, "_result"}, 78'(lk_result), 78'(exp_res));
  endtask

  task automatic idle();
    tlbrw_we = 1'b0;
    lk_req   = 1'b0;
  endtask

  task automatic wr(input logic [3:0] idx, input tlb_entry_t e);
    tlbrw_index = idx;
    tlbrw_wdata = e;
    tlbrw_we    = 1'b1;
  endtask

  task automatic look(input logic [31:0] va, input logic [7:0] asid);
    lk_req   = 1'b1;
    lk_vaddr = va;
    lk_asid  = asid;
  endtask

  // ---------------- stimulus ----------------
  tlb_entry_t e5;
  initial begin
    resetn = 1'b0; tlbrw_index = '0; tlbrw_we = 1'b0; tlbrw_wdata = '0;
    tlbp_entry_hi = '0; lk_req = 1'b0; lk_vaddr = '0; lk_asid = '0;
    for (int i = 0; i < 16; i++) begin
      m_live[i] = 1'b0;
      m_ent[i]  = '0;
    end
    exp_res = '0;

    // 1: reset values, then all-zero probe/lookup miss
    step("rst0");
    step("rst1");
    resetn = 1'b1;
    look(32'h0, 8'h0);
    step("t1");
    chk("t1_probe_const", 78'(tlbp_index), 78'(32'h8000_0000));
    chk("t1_miss_const", 78'(lk_result[5]), 78'(1'b1));

    // 2: write idx3, translate on the following cycle
    idle();
    wr(4'd3, mk(19'h00400, 8'h05, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    step("t2w");
    idle();
    look(32'h0080_0ABC, 8'h05);
    step("t2l");
    chk("t2_result_const", 78'(lk_result), 78'({32'h1234_5ABC, 4'd3, 1'b0, 1'b1, 1'b1, 3'd3}));

    // 3: ASID mismatch misses; global bit makes it hit
    look(32'h0080_0ABC, 8'h06);
    step("t3miss");
    chk("t3_miss_const", 78'(lk_result[5]), 78'(1'b1));
    idle();
    wr(4'd3, mk(19'h00400, 8'h05, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
    step("t3w");
    idle();
    look(32'h0080_0ABC, 8'h06);
    step("t3hit");
    chk("t3_which_const", 78'(lk_result[9:6]), 78'(4'd3));

    // 4: duplicate VPN2 in entries 2 and 7, lowest index wins; odd half selected
    idle();
    wr(4'd7, mk(19'h1, 8'h00, 1'b1, 20'h11111, 3'd1, 1'b0, 1'b1, 20'hBBBBB, 3'd5, 1'b0, 1'b1));
    step("t4w7");
    wr(4'd2, mk(19'h1, 8'h00, 1'b1, 20'h22222, 3'd2, 1'b0, 1'b0, 20'hAAAAA, 3'd4, 1'b1, 1'b1));
    step("t4w2");
    idle();
    tlbp_entry_hi = 32'h0000_2000;
    look(32'h0000_3123, 8'h44);
    step("t4p");
    chk("t4_probe_const", 78'(tlbp_index), 78'(32'h0000_0002));
    chk("t4_phy_const", 78'(lk_result[41:10]), 78'(32'hAAAA_A123));

    // 5: write+read same index same cycle, then read again; back-to-back lookups
    idle();
    e5 = mk(19'h7ABCD, 8'h33, 1'b0, 20'hFEDCB, 3'd7, 1'b1, 1'b0, 20'h54321, 3'd6, 1'b0, 1'b1);
    wr(4'd5, e5);
    step("t5wr");
    chk("t5_old_const", tlbrw_rdata, 78'(0));
    idle();
    step("t5rd");
    chk("t5_new_const", tlbrw_rdata, e5);
    look(32'h0080_0123, 8'h05);  step("t5b0");
    look(32'h0000_3FFF, 8'h01);  step("t5b1");
    look(32'hF579_A000, 8'h33);  step("t5b2");
    look(32'hF579_B456, 8'h33);  step("t5b3");
    idle();
    step("t5idle");

    // 6: reset on the request edge cancels the result and kills all entries
    look(32'h0080_0ABC, 8'h05);
    resetn = 1'b0;
    step("t6rst");
    chk("t6_rvalid_const", 78'(lk_rvalid), 78'(1'b0));
    resetn = 1'b1;
    tlbp_entry_hi = 32'h0080_0005;
    look(32'h0000_3123, 8'h00);
    step("t6a");
    tlbp_entry_hi = 32'hF579_A033;
    look(32'h0080_0ABC, 8'h05);
    step("t6b");
    chk("t6_miss_const", 78'({tlbp_index[31], lk_result[5]}), 78'(2'b11));

    // 7: randomized traffic over a small key space to force hits and duplicates
    for (int n = 0; n < 400; n++) begin
      tlbrw_index = 4'($urandom_range(0, 15));
      tlbrw_we    = ($urandom_range(0, 3) == 0);
      tlbrw_wdata = mk(19'($urandom_range(0, 3)), 8'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)), 20'($urandom), 3'($urandom),
                       1'($urandom), 1'($urandom), 20'($urandom), 3'($urandom),
                       1'($urandom), 1'($urandom));
      tlbp_entry_hi = {19'($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 2))};
      lk_req   = ($urandom_range(0, 3) != 0);
      lk_vaddr = {19'($urandom_range(0, 3)), 13'($urandom)};
      lk_asid  = 8'($urandom_range(0, 2));
      resetn   = ($urandom_range(0, 99) != 0);
      step("rnd");
      resetn = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
